// File: rtl/se2pa_pkg.sv
// Shared definitions for the FFT serial/parallel converters: sample width, lane geometry, lane map.
// Lane ordering follows SE2PA_BITREV_EN: defined gives bit-reversed (DIF) order, undefined gives natural order.
package se2pa_pkg;

   localparam int NB_DEFAULT = 16;
   localparam int LANES      = 4;
   localparam int LANE_W     = 2;

   typedef logic [LANE_W-1:0] lane_t;

   function automatic lane_t bitrev2(input lane_t k);
      return {k[0], k[1]};
   endfunction

   // The unpacker at stage outputs uses this same map, so both ends agree on lane order.
   function automatic lane_t lane_map(input lane_t k);
`ifdef SE2PA_BITREV_EN
      return bitrev2(k);
`else
      return k;
`endif
   endfunction

endpackage

// File: rtl/se2pa.sv
// Serial-to-parallel collector: gathers four complex samples into one 4-lane word and strobes RDY.
// Lane order is selected by SE2PA_BITREV_EN (see se2pa_pkg::lane_map).
module se2pa
   import se2pa_pkg::*;
#(
   parameter int NB = NB_DEFAULT
)
(
   input  logic                CLK,
   input  logic                RST,
   input  logic                START,
   input  logic                DV,
   input  logic [NB-1:0]       DR,
   input  logic [NB-1:0]       DI,
   output logic [LANES*NB-1:0] OR,
   output logic [LANES*NB-1:0] OI,
   output logic                RDY,
   output logic [LANE_W-1:0]   CNT
);

   // Handshake: a sample is accepted on every edge where DV=1 (no backpressure);
   // RDY is a single-cycle strobe, and OR/OI hold that word until the next RDY.

   logic [LANES*NB-1:0] ar;
   logic [LANES*NB-1:0] ai;
   logic [LANES*NB-1:0] ar_nxt;
   logic [LANES*NB-1:0] ai_nxt;
   lane_t               wr_lane;
   lane_t               cnt_nxt;
   logic                complete;

   always_comb begin
      ar_nxt   = ar;
      ai_nxt   = ai;
      cnt_nxt  = CNT;
      // START restarts the frame, so the current sample lands in lane 0.
      wr_lane  = START ? lane_map(lane_t'(0)) : lane_map(CNT);
      complete = DV && !START && (CNT == lane_t'(LANES - 1));

      if (DV) begin
         for (int k = 0; k < LANES; k++) begin
            if (wr_lane == lane_t'(k)) begin
               ar_nxt[k*NB +: NB] = DR;
               ai_nxt[k*NB +: NB] = DI;
            end
         end
      end

      if (START) begin
         cnt_nxt = DV ? lane_t'(1) : lane_t'(0);
      end else if (DV) begin
         cnt_nxt = CNT + lane_t'(1);
      end
   end

   // The last sample maps to lane 3 in both orders, so ar_nxt is the full word.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ar  <= '0;
         ai  <= '0;
         OR  <= '0;
         OI  <= '0;
         RDY <= 1'b0;
         CNT <= '0;
      end else begin
         ar  <= ar_nxt;
         ai  <= ai_nxt;
         CNT <= cnt_nxt;
         RDY <= complete;
         if (complete) begin
            OR <= ar_nxt;
            OI <= ai_nxt;
         end
      end
   end

endmodule

// File: tb/tb_se2pa.sv
// Bench for se2pa: table-driven steps with per-cycle RDY/CNT expectations and a word scoreboard.
module tb_se2pa;

   localparam int NB = 16;
   localparam int W  = 4 * NB;

   logic          CLK;
   logic          RST;
   logic          START;
   logic          DV;
   logic [NB-1:0] DR;
   logic [NB-1:0] DI;
   logic [W-1:0]  OR;
   logic [W-1:0]  OI;
   logic          RDY;
   logic [1:0]    CNT;

   se2pa #(.NB(NB)) dut (
      .CLK(CLK), .RST(RST), .START(START), .DV(DV), .DR(DR), .DI(DI),
      .OR(OR), .OI(OI), .RDY(RDY), .CNT(CNT)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic          start;
      logic          dv;
      logic [NB-1:0] dr;
      logic [NB-1:0] di;
      logic          exp_rdy;
      logic [1:0]    exp_cnt;
   } vec_t;

   vec_t           vecs[$];
   logic [2*W-1:0] exp_q[$];
   logic [W-1:0]   last_or;
   logic [W-1:0]   last_oi;
   int             checks;
   int             failures;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Expected word from four samples in arrival order, placed by lane order.
   function automatic logic [W-1:0] make_word(input logic [NB-1:0] s0, s1, s2, s3);
`ifdef SE2PA_BITREV_EN
      return {s3, s1, s2, s0};
`else
      return {s3, s2, s1, s0};
`endif
   endfunction

   task automatic push_word(input logic [W-1:0] wr, input logic [W-1:0] wi);
      exp_q.push_back({wr, wi});
   endtask

   task automatic add(input logic st, input logic dv, input logic [NB-1:0] dr,
                      input logic [NB-1:0] di, input logic rdy, input logic [1:0] cnt);
      vec_t v;
      v.start = st; v.dv = dv; v.dr = dr; v.di = di; v.exp_rdy = rdy; v.exp_cnt = cnt;
      vecs.push_back(v);
   endtask

   // driver: apply one step, then check after the edge
   task automatic apply(input vec_t v);
      logic [2*W-1:0] e;
      START = v.start; DV = v.dv; DR = v.dr; DI = v.di;
      @(posedge CLK);
      #1;
      chk("rdy", W'(RDY), W'(v.exp_rdy));
      chk("cnt", W'(CNT), W'(v.exp_cnt));
      if (v.exp_rdy) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=RDY expected=no_word t=%0t", $time);
         end else begin
            e = exp_q.pop_front();
            chk("or_word", OR, e[2*W-1:W]);
            chk("oi_word", OI, e[W-1:0]);
            last_or = e[2*W-1:W];
            last_oi = e[W-1:0];
         end
      end else begin
         chk("or_hold", OR, last_or);
         chk("oi_hold", OI, last_oi);
      end
   endtask

   task automatic run_vecs();
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
      vecs.delete();
      START = 1'b0; DV = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_or"}, OR, '0);
      chk({tag, "_oi"}, OI, '0);
      chk({tag, "_rdy"}, W'(RDY), '0);
      chk({tag, "_cnt"}, W'(CNT), '0);
   endtask

   initial begin
      logic [NB-1:0] rr[4];
      logic [NB-1:0] ri[4];
      logic [1:0]    c;
      vec_t          v;
      checks = 0; failures = 0;
      last_or = '0; last_oi = '0;
      RST = 1'b0; START = 1'b0; DV = 1'b0; DR = '0; DI = '0;
      #12;
      chk_reset_state("reset");
      @(posedge CLK); #1;
      RST = 1'b1;

      // basic frame
      push_word(make_word(1, 2, 3, 4), make_word('h11, 'h22, 'h33, 'h44));
      add(0, 1, 1, 'h11, 0, 1);
      add(0, 1, 2, 'h22, 0, 2);
      add(0, 1, 3, 'h33, 0, 3);
      add(0, 1, 4, 'h44, 1, 0);
      add(0, 0, 0, 0, 0, 0);
      run_vecs();

      // gap of three idle cycles mid-frame
      push_word(make_word(1, 2, 3, 4), make_word('h11, 'h22, 'h33, 'h44));
      add(0, 1, 1, 'h11, 0, 1);
      add(0, 1, 2, 'h22, 0, 2);
      add(0, 0, 'h77, 'h77, 0, 2);
      add(0, 0, 'h77, 'h77, 0, 2);
      add(0, 0, 'h77, 'h77, 0, 2);
      add(0, 1, 3, 'h33, 0, 3);
      add(0, 1, 4, 'h44, 1, 0);
      add(0, 0, 0, 0, 0, 0);
      run_vecs();

      // twelve continuous samples, three back-to-back words
      for (int f = 0; f < 3; f++) begin
         push_word(make_word(NB'(4*f+1), NB'(4*f+2), NB'(4*f+3), NB'(4*f+4)),
                   make_word(NB'(4*f+'h101), NB'(4*f+'h102), NB'(4*f+'h103), NB'(4*f+'h104)));
         for (int k = 0; k < 4; k++)
            add(0, 1, NB'(4*f+k+1), NB'(4*f+k+'h101), (k == 3), 2'(k+1));
      end
      add(0, 0, 0, 0, 0, 0);
      run_vecs();

      // START with DV discards a partial frame of three samples
      push_word(make_word(9, 10, 11, 12), make_word('h99, 'hAA, 'hBB, 'hCC));
      add(0, 1, 1, 'h11, 0, 1);
      add(0, 1, 2, 'h22, 0, 2);
      add(0, 1, 3, 'h33, 0, 3);
      add(1, 1, 9, 'h99, 0, 1);
      add(0, 1, 10, 'hAA, 0, 2);
      add(0, 1, 11, 'hBB, 0, 3);
      add(0, 1, 12, 'hCC, 1, 0);
      add(0, 0, 0, 0, 0, 0);
      run_vecs();

      // START without DV, then a fresh frame
      push_word(make_word(5, 6, 7, 8), make_word('h55, 'h66, 'h77, 'h88));
      add(0, 1, 1, 'h11, 0, 1);
      add(0, 1, 2, 'h22, 0, 2);
      add(1, 0, 'h3, 'h33, 0, 0);
      add(0, 1, 5, 'h55, 0, 1);
      add(0, 1, 6, 'h66, 0, 2);
      add(0, 1, 7, 'h77, 0, 3);
      add(0, 1, 8, 'h88, 1, 0);
      add(0, 0, 0, 0, 0, 0);
      run_vecs();

      // asynchronous reset mid-frame
      add(0, 1, 1, 'h11, 0, 1);
      add(0, 1, 2, 'h22, 0, 2);
      run_vecs();
      #2;
      RST = 1'b0;
      #1;
      chk_reset_state("async_reset");
      last_or = '0; last_oi = '0;
      @(posedge CLK); #1;
      chk_reset_state("reset_hold");
      RST = 1'b1;
      push_word(make_word(5, 6, 7, 8), make_word('h55, 'h66, 'h77, 'h88));
      add(0, 1, 5, 'h55, 0, 1);
      add(0, 1, 6, 'h66, 0, 2);
      add(0, 1, 7, 'h77, 0, 3);
      add(0, 1, 8, 'h88, 1, 0);
      add(0, 0, 0, 0, 0, 0);
      run_vecs();

      // random frames with random idle gaps
      for (int f = 0; f < 6; f++) begin
         for (int k = 0; k < 4; k++) begin
            rr[k] = NB'($urandom_range(0, 65535));
            ri[k] = NB'($urandom_range(0, 65535));
         end
         push_word(make_word(rr[0], rr[1], rr[2], rr[3]), make_word(ri[0], ri[1], ri[2], ri[3]));
         c = 2'd0;
         for (int k = 0; k < 4; k++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
               v.start = 0; v.dv = 0; v.dr = NB'($urandom); v.di = NB'($urandom);
               v.exp_rdy = 0; v.exp_cnt = c;
               apply(v);
            end
            c = c + 2'd1;
            v.start = 0; v.dv = 1; v.dr = rr[k]; v.di = ri[k];
            v.exp_rdy = (k == 3); v.exp_cnt = c;
            apply(v);
         end
      end
      START = 1'b0; DV = 1'b0;
      @(posedge CLK); #1;
      chk("rdy_final", W'(RDY), '0);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
